// File: rtl/sonic_array.sv
// rtl/sonic_array.sv - round-robin multi-channel ultrasonic ranger with zone classification
// Fires one sensor per slot, times its echo in microseconds and divides by US_PER_CM to get centimetres.
module sonic_array #(
   parameter int CLK_HZ     = 50000000,
   parameter int N_CH       = 2,
   parameter int DIST_W     = 9,
   parameter int TRIG_US    = 10,
   parameter int SLOT_US    = 40000,
   parameter int TIMEOUT_US = 30000,
   parameter int US_PER_CM  = 58,
   parameter int NEAR_CM    = 10,
   parameter int MID_CM     = 30,
   parameter int FAR_CM     = 50
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [N_CH-1:0]        echo,
   output logic [N_CH-1:0]        trig,
   output logic [N_CH*DIST_W-1:0] distance,
   output logic [N_CH*2-1:0]      zone,
   output logic [N_CH-1:0]        timeout,
   output logic                   valid,
   output logic [2:0]             valid_ch,
   output logic                   buzzer,
   output logic                   red_led,
   output logic                   green_led,
   output logic                   blue_led
);

   localparam int DIV      = CLK_HZ / 1000000;
   localparam int TKW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TRIG_CLK = TRIG_US * DIV;
   localparam int SLOT_CLK = SLOT_US * DIV;
   // Slot timer is sized for twice the slot so a late rise plus a long echo cannot wrap it
   localparam int SW       = $clog2(2 * SLOT_CLK);
   localparam int CW0      = $clog2(TIMEOUT_US + 1);
   localparam int CW1      = $clog2(US_PER_CM + 1);
   localparam int CW       = (CW0 > CW1) ? CW0 : CW1;
   localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [TKW-1:0]  TK_MAX   = TKW'(DIV - 1);
   localparam logic [SW-1:0]   TRIG_END = SW'(TRIG_CLK - 1);
   localparam logic [SW-1:0]   SLOT_END = SW'(SLOT_CLK - 1);
   localparam logic [CW-1:0]   TMO_END  = CW'(TIMEOUT_US - 1);
   localparam logic [CW-1:0]   DIVISOR  = CW'(US_PER_CM);
   localparam logic [N_CH-1:0] ONE      = N_CH'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DIVIDE, S_RESULT, S_WAIT_SLOT
   } state_t;

   state_t                  r_state;
   logic [TKW-1:0]          r_tick_cnt;
   logic [N_CH-1:0]         r_sync1, r_sync2, r_prev;
   logic [CHW-1:0]          r_ch;
   logic [SW-1:0]           r_slot;
   logic [CW-1:0]           r_cnt;
   logic [CW-1:0]           r_rem;
   logic [DIST_W-1:0]       r_quo;
   logic                    r_tmo;
   logic [N_CH-1:0]         r_trig;
   logic [N_CH*DIST_W-1:0]  r_dist;
   logic [N_CH*2-1:0]       r_zone;
   logic [N_CH-1:0]         r_tmo_o;
   logic [N_CH-1:0]         r_meas;
   logic                    r_valid;
   logic [2:0]              r_valid_ch;
   logic                    r_buzzer, r_red, r_green, r_blue;

   logic                    w_us_tick;
   logic                    w_echo;
   logic                    w_rise;
   logic [CHW-1:0]          w_ch_next;
   logic                    w_any;
   logic [DIST_W-1:0]       w_min;
   logic [1:0]              w_min_zone;

   function automatic logic [1:0] f_zone(input logic [DIST_W-1:0] d);
      if (d < DIST_W'(NEAR_CM))      return 2'd0;
      else if (d < DIST_W'(MID_CM))  return 2'd1;
      else if (d <= DIST_W'(FAR_CM)) return 2'd2;
      else                           return 2'd3;
   endfunction

   assign w_us_tick = (r_tick_cnt == TK_MAX);
   assign w_echo    = r_sync2[r_ch];
   assign w_rise    = r_sync2[r_ch] & ~r_prev[r_ch];
   assign w_ch_next = (r_ch == CHW'(N_CH - 1)) ? '0 : r_ch + CHW'(1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_tick_cnt <= '0;
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_prev     <= '0;
      end else begin
         r_tick_cnt <= w_us_tick ? '0 : r_tick_cnt + TKW'(1);
         r_sync1    <= echo;
         r_sync2    <= r_sync1;
         r_prev     <= r_sync2;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_ch       <= '0;
         r_slot     <= '0;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_tmo      <= 1'b0;
         r_trig     <= '0;
         r_dist     <= '0;
         r_zone     <= '1;
         r_tmo_o    <= '0;
         r_meas     <= '0;
         r_valid    <= 1'b0;
         r_valid_ch <= '0;
      end else begin
         r_valid <= 1'b0;
         if (r_state != S_IDLE) r_slot <= r_slot + SW'(1);
         // Losing enable abandons the slot; stored results and the channel pointer survive
         if (r_state != S_IDLE && !enable) begin
            r_state <= S_IDLE;
            r_trig  <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_slot <= '0;
                  if (enable) begin
                     r_state <= S_TRIG;
                     r_trig  <= ONE << r_ch;
                     r_tmo   <= 1'b0;
                  end
               end
               S_TRIG: begin
                  if (r_slot == TRIG_END) begin
                     r_trig  <= '0;
                     r_cnt   <= '0;
                     r_state <= S_WAIT_RISE;
                  end
               end
               S_WAIT_RISE: begin
                  if (w_rise) begin
                     r_cnt   <= '0;
                     r_state <= S_MEASURE;
                  end else if (w_us_tick) begin
                     if (r_cnt == TMO_END) begin
                        r_tmo   <= 1'b1;
                        r_state <= S_RESULT;
                     end else begin
                        r_cnt <= r_cnt + CW'(1);
                     end
                  end
               end
               S_MEASURE: begin
                  if (!w_echo) begin
                     r_rem   <= r_cnt;
                     r_quo   <= '0;
                     r_state <= S_DIVIDE;
                  end else if (w_us_tick) begin
                     if (r_cnt == TMO_END) begin
                        r_tmo   <= 1'b1;
                        r_state <= S_RESULT;
                     end else begin
                        r_cnt <= r_cnt + CW'(1);
                     end
                  end
               end
               S_DIVIDE: begin
                  if (r_rem < DIVISOR) begin
                     r_state <= S_RESULT;
                  end else begin
                     r_rem <= r_rem - DIVISOR;
                     if (r_quo != '1) r_quo <= r_quo + DIST_W'(1);
                  end
               end
               S_RESULT: begin
                  r_dist[r_ch*DIST_W +: DIST_W] <= r_tmo ? '1 : r_quo;
                  r_zone[r_ch*2 +: 2]           <= r_tmo ? 2'd3 : f_zone(r_quo);
                  r_tmo_o[r_ch]                 <= r_tmo;
                  r_meas[r_ch]                  <= 1'b1;
                  r_valid                       <= 1'b1;
                  r_valid_ch                    <= 3'(r_ch);
                  r_state                       <= S_WAIT_SLOT;
               end
               S_WAIT_SLOT: begin
                  if (r_slot >= SLOT_END) begin
                     r_ch    <= w_ch_next;
                     r_slot  <= '0;
                     r_trig  <= ONE << w_ch_next;
                     r_tmo   <= 1'b0;
                     r_state <= S_TRIG;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Nearest channel among those holding a real (non-timed-out) measurement
   always_comb begin
      w_any = 1'b0;
      w_min = '1;
      for (int k = 0; k < N_CH; k++) begin
         if (r_meas[k] && !r_tmo_o[k] && (!w_any || r_dist[k*DIST_W +: DIST_W] < w_min)) begin
            w_min = r_dist[k*DIST_W +: DIST_W];
            w_any = 1'b1;
         end
      end
   end

   assign w_min_zone = f_zone(w_min);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_buzzer <= 1'b0;
         r_red    <= 1'b1;
         r_green  <= 1'b1;
         r_blue   <= 1'b1;
      end else if (!w_any) begin
         r_buzzer <= 1'b0;
         r_red    <= 1'b1;
         r_green  <= 1'b1;
         r_blue   <= 1'b1;
      end else begin
         r_buzzer <= (w_min_zone == 2'd0);
         r_red    <= (w_min_zone != 2'd0);
         r_green  <= (w_min_zone != 2'd1);
         r_blue   <= (w_min_zone != 2'd2);
      end
   end

   assign trig      = r_trig & {N_CH{enable}};
   assign distance  = r_dist;
   assign zone      = r_zone;
   assign timeout   = r_tmo_o;
   assign valid     = r_valid;
   assign valid_ch  = r_valid_ch;
   assign buzzer    = r_buzzer;
   assign red_led   = r_red;
   assign green_led = r_green;
   assign blue_led  = r_blue;

endmodule

// File: tb/tb_sonic_array.sv
// tb/tb_sonic_array.sv - directed bench for sonic_array, 2 channels at 2 MHz with a shortened slot
`timescale 1ns/1ps
module tb_sonic_array;

   localparam int N_CH   = 2;
   localparam int DIST_W = 9;
   localparam int SLOT_C = 7200;

   logic                   clock = 1'b0;
   logic                   reset_n;
   logic                   enable;
   logic [N_CH-1:0]        echo;
   logic [N_CH-1:0]        trig;
   logic [N_CH*DIST_W-1:0] distance;
   logic [N_CH*2-1:0]      zone;
   logic [N_CH-1:0]        timeout;
   logic                   valid;
   logic [2:0]             valid_ch;
   logic                   buzzer, red_led, green_led, blue_led;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int vcount = 0;
   int overlap = 0;
   int t_rise_a = 0;

   sonic_array #(
      .CLK_HZ(2000000), .N_CH(N_CH), .DIST_W(DIST_W), .TRIG_US(10), .SLOT_US(3600),
      .TIMEOUT_US(3100), .US_PER_CM(58), .NEAR_CM(10), .MID_CM(30), .FAR_CM(50)
   ) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .echo(echo), .trig(trig),
      .distance(distance), .zone(zone), .timeout(timeout), .valid(valid), .valid_ch(valid_ch),
      .buzzer(buzzer), .red_led(red_led), .green_led(green_led), .blue_led(blue_led)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) begin
      if (valid === 1'b1) vcount++;
      if (trig === 2'b11) overlap++;
   end

   task automatic run_slot(input int ch, input int pre_us, input int width_us,
                           output int t_rise, output int twidth, output int lat_fall,
                           output int lat_rise, output int nvalid);
      int n, tf, v0;
      n = 0;
      while (trig[ch] !== 1'b1 && n < 20000) begin @(negedge clock); n++; end
      checks++;
      if (trig[ch] !== 1'b1) begin errors++; $display("FAIL trig_rise ch%0d: not seen in %0d cycles", ch, n); end
      t_rise = cyc;
      twidth = 0;
      while (trig[ch] === 1'b1 && twidth < 1000) begin @(negedge clock); twidth++; end
      v0 = vcount;
      if (width_us > 0) begin
         repeat (2*pre_us) @(negedge clock);
         echo[ch] = 1'b1;
         repeat (2*width_us) @(negedge clock);
         echo[ch] = 1'b0;
      end
      tf = cyc;
      n = 0;
      while (valid !== 1'b1 && n < 8000) begin @(negedge clock); n++; end
      checks++;
      if (valid !== 1'b1) begin errors++; $display("FAIL valid_wait ch%0d: no valid in %0d cycles", ch, n); end
      lat_fall = cyc - tf;
      lat_rise = cyc - t_rise;
      repeat (4) @(negedge clock);
      nvalid = vcount - v0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; enable = 1'b0; echo = '0;
      repeat (3) @(negedge clock);
      checks++; if (trig !== 2'b00) begin errors++; $display("FAIL reset_trig: got %b want 00", trig); end
      checks++; if (distance !== '0) begin errors++; $display("FAIL reset_distance: got %h want 0", distance); end
      checks++; if (zone !== 4'hF) begin errors++; $display("FAIL reset_zone: got %h want f", zone); end
      checks++; if ({timeout, valid, valid_ch} !== 6'd0) begin errors++; $display("FAIL reset_flags: got %b want 0", {timeout, valid, valid_ch}); end
      checks++; if ({buzzer, red_led, green_led, blue_led} !== 4'b0111) begin errors++; $display("FAIL reset_leds: got %b want 0111", {buzzer, red_led, green_led, blue_led}); end
      reset_n = 1'b1;
      repeat (20) @(negedge clock);
      checks++; if (trig !== 2'b00) begin errors++; $display("FAIL idle_trig: got %b want 00", trig); end
   endtask

   task automatic test_first_range;
      int tr, tw, lf, lr, nv, d;
      enable = 1'b1;
      run_slot(0, 100, 1160, tr, tw, lf, lr, nv);
      t_rise_a = tr;
      d = int'(distance[8:0]);
      checks++; if (tw != 20) begin errors++; $display("FAIL trig_width: got %0d want 20 clocks", tw); end
      checks++; if (d < 19 || d > 20) begin errors++; $display("FAIL dist_1160: got %0d want 19..20", d); end
      checks++; if (zone[1:0] !== 2'd1) begin errors++; $display("FAIL zone_1160: got %0d want 1", zone[1:0]); end
      checks++; if (timeout[0] !== 1'b0) begin errors++; $display("FAIL tmo_1160: got %b want 0", timeout[0]); end
      checks++; if (nv != 1) begin errors++; $display("FAIL valid_count_a: got %0d want 1", nv); end
      checks++; if (valid_ch !== 3'd0) begin errors++; $display("FAIL valid_ch_a: got %0d want 0", valid_ch); end
      checks++; if ({buzzer, red_led, green_led, blue_led} !== 4'b0101) begin errors++; $display("FAIL leds_a: got %b want 0101", {buzzer, red_led, green_led, blue_led}); end
   endtask

   task automatic test_second_channel;
      int tr, tw, lf, lr, nv, d;
      run_slot(1, 100, 2900, tr, tw, lf, lr, nv);
      d = int'(distance[17:9]);
      checks++; if (tr - t_rise_a != SLOT_C) begin errors++; $display("FAIL slot_spacing: got %0d want %0d clocks", tr - t_rise_a, SLOT_C); end
      checks++; if (tw != 20) begin errors++; $display("FAIL trig_width_b: got %0d want 20 clocks", tw); end
      checks++; if (d < 49 || d > 50) begin errors++; $display("FAIL dist_2900: got %0d want 49..50", d); end
      checks++; if (zone[3:2] !== 2'd2) begin errors++; $display("FAIL zone_2900: got %0d want 2", zone[3:2]); end
      checks++; if (valid_ch !== 3'd1) begin errors++; $display("FAIL valid_ch_b: got %0d want 1", valid_ch); end
      checks++; if ({buzzer, red_led, green_led, blue_led} !== 4'b0101) begin errors++; $display("FAIL leds_b: got %b want 0101", {buzzer, red_led, green_led, blue_led}); end
   endtask

   task automatic test_far_and_divide;
      int tr, tw, lf, lr, nv;
      run_slot(0, 100, 3050, tr, tw, lf, lr, nv);
      checks++; if (distance[8:0] !== 9'd52) begin errors++; $display("FAIL dist_3050: got %0d want 52", distance[8:0]); end
      checks++; if (zone[1:0] !== 2'd3) begin errors++; $display("FAIL zone_3050: got %0d want 3", zone[1:0]); end
      checks++; if (lf > 60) begin errors++; $display("FAIL divide_latency: got %0d want <= 60 clocks", lf); end
      checks++; if ({buzzer, red_led, green_led, blue_led} !== 4'b0110) begin errors++; $display("FAIL leds_c: got %b want 0110", {buzzer, red_led, green_led, blue_led}); end
   endtask

   task automatic test_timeouts;
      int tr, tw, lf, lr, nv;
      run_slot(1, 0, 0, tr, tw, lf, lr, nv);
      checks++; if (distance[17:9] !== 9'd511) begin errors++; $display("FAIL dist_noecho: got %0d want 511", distance[17:9]); end
      checks++; if (timeout !== 2'b10 || zone[3:2] !== 2'd3) begin errors++; $display("FAIL tmo_noecho: got tmo=%b zone=%0d want 10/3", timeout, zone[3:2]); end
      checks++; if (lr < 6215 || lr > 6230) begin errors++; $display("FAIL tmo_latency: got %0d want 6215..6230", lr); end
      checks++; if ({buzzer, red_led, green_led, blue_led} !== 4'b0111) begin errors++; $display("FAIL leds_d: got %b want 0111", {buzzer, red_led, green_led, blue_led}); end
      echo[0] = 1'b1;
      run_slot(0, 0, 0, tr, tw, lf, lr, nv);
      echo[0] = 1'b0;
      checks++; if (distance[8:0] !== 9'd511 || timeout !== 2'b11) begin errors++; $display("FAIL stuck_high: got d=%0d tmo=%b want 511/11", distance[8:0], timeout); end
      checks++; if (lr < 6215 || lr > 6230) begin errors++; $display("FAIL stuck_latency: got %0d want 6215..6230", lr); end
      checks++; if ({buzzer, red_led, green_led, blue_led} !== 4'b0111) begin errors++; $display("FAIL leds_e: got %b want 0111", {buzzer, red_led, green_led, blue_led}); end
   endtask

   task automatic test_two_channel_zones;
      int tr, tw, lf, lr, nv;
      run_slot(1, 100, 1800, tr, tw, lf, lr, nv);
      checks++; if (distance[17:9] !== 9'd31 || timeout[1] !== 1'b0) begin errors++; $display("FAIL dist_1800: got %0d tmo=%b want 31/0", distance[17:9], timeout[1]); end
      checks++; if ({buzzer, red_led, green_led, blue_led} !== 4'b0110) begin errors++; $display("FAIL leds_f: got %b want 0110", {buzzer, red_led, green_led, blue_led}); end
      run_slot(0, 100, 300, tr, tw, lf, lr, nv);
      checks++; if (distance[8:0] !== 9'd5 || zone !== 4'b1000) begin errors++; $display("FAIL dist_300: got %0d zone=%b want 5/1000", distance[8:0], zone); end
      checks++; if ({buzzer, red_led, green_led, blue_led} !== 4'b1011) begin errors++; $display("FAIL leds_g: got %b want 1011", {buzzer, red_led, green_led, blue_led}); end
      checks++; if (overlap != 0) begin errors++; $display("FAIL trig_exclusive: got %0d overlapping cycles want 0", overlap); end
   endtask

   task automatic test_enable_drop;
      int n, v0;
      n = 0;
      while (trig[1] !== 1'b1 && n < 20000) begin @(negedge clock); n++; end
      n = 0;
      while (trig[1] === 1'b1 && n < 100) begin @(negedge clock); n++; end
      repeat (200) @(negedge clock);
      echo[1] = 1'b1;
      repeat (1000) @(negedge clock);
      v0 = vcount;
      enable = 1'b0;
      @(negedge clock);
      checks++; if (trig !== 2'b00) begin errors++; $display("FAIL drop_trig: got %b want 00", trig); end
      repeat (400) @(negedge clock);
      echo[1] = 1'b0;
      repeat (200) @(negedge clock);
      checks++; if (vcount != v0) begin errors++; $display("FAIL drop_novalid: got %0d pulses want 0", vcount - v0); end
      checks++; if (distance[17:9] !== 9'd31 || zone[3:2] !== 2'd2) begin errors++; $display("FAIL drop_kept: got %0d zone=%0d want 31/2", distance[17:9], zone[3:2]); end
      enable = 1'b1;
      @(negedge clock);
      checks++; if (trig !== 2'b10) begin errors++; $display("FAIL resume_ch: got %b want 10", trig); end
      repeat (5) @(negedge clock);
      enable = 1'b0;
      #1;
      checks++; if (trig !== 2'b00) begin errors++; $display("FAIL trig_drop_now: got %b want 00", trig); end
   endtask

   task automatic test_async_reset;
      int n;
      @(negedge clock);
      enable = 1'b1;
      n = 0;
      while (trig[1] !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      while (trig[1] === 1'b1 && n < 100) begin @(negedge clock); n++; end
      repeat (100) @(negedge clock);
      echo[1] = 1'b1;
      repeat (400) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (trig !== 2'b00 || distance !== '0 || zone !== 4'hF) begin errors++; $display("FAIL async_reset_data: got trig=%b d=%h zone=%h want 00/0/f", trig, distance, zone); end
      checks++; if ({timeout, valid, valid_ch, buzzer, red_led, green_led, blue_led} !== 10'b0000000111) begin errors++; $display("FAIL async_reset_flags: got %b want 0000000111", {timeout, valid, valid_ch, buzzer, red_led, green_led, blue_led}); end
      echo = '0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checks++; if (trig !== 2'b01) begin errors++; $display("FAIL restart_ch0: got %b want 01", trig); end
   endtask

   initial begin
      test_reset;
      test_first_range;
      test_second_channel;
      test_far_and_divide;
      test_timeouts;
      test_two_channel_zones;
      test_enable_drop;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
